// File: rtl/dmem_responder.sv
// Data-memory responder for an RV32I core: single-outstanding request/response
// handshake with a configurable number of wait states, byte/half/word
// loads and stores with little-endian lane selection, and error reporting
// for misaligned, out-of-range or illegal-size accesses.
//
// Ports:
//   Clk        clock, rising edge
//   Rst        asynchronous reset, active low (memory contents are kept)
//   ReqValid   core presents a request
//   ReqReady   responder can accept a request (IDLE only)
//   ReqWrite   1 = store, 0 = load
//   ReqAddr    byte address
//   ReqWData   store data, right-aligned
//   ReqFunct3  RV32I size code
//   RspValid   response available (RESP only)
//   RspReady   core accepts the response
//   RspRData   extended load data; 0 for stores and errors
//   RspErr     request rejected
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [2:0]  ReqFunct3,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspRData,
  output logic        RspErr
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  f3_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;

  logic        acc_write;
  logic [31:0] acc_addr, acc_wdata;
  logic [2:0]  acc_f3;
  logic [AW-1:0] idx;
  logic [31:0] word;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        f3_bad, misalign, oor, err;
  logic [31:0] load_data, rdata;
  logic [3:0]  be;
  logic [31:0] wd_lanes;
  logic        we;

  assign ReqReady = (state_q == IDLE);
  assign RspValid = (state_q == RESP);
  assign RspRData = rdata_q;
  assign RspErr   = err_q;
  assign accept   = ReqReady && ReqValid;

  // With zero wait states the access happens on the accept edge itself, so
  // the datapath works from the live request inputs while IDLE and from the
  // captured copy otherwise.
  always_comb begin
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_f3    = f3_q;
    if (state_q == IDLE) begin
      acc_write = ReqWrite;
      acc_addr  = ReqAddr;
      acc_wdata = ReqWData;
      acc_f3    = ReqFunct3;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d      = '0;
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (RspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= ReqWrite;
        addr_q  <= ReqAddr;
        wdata_q <= ReqWData;
        f3_q    <= ReqFunct3;
      end
      if (enter_resp) begin
        rdata_q <= rdata;
        err_q   <= err;
      end
    end
  end

  // Access decode and error detection.
  always_comb begin
    idx      = acc_addr[AW+1:2];
    word     = mem[idx];
    f3_bad   = (acc_f3 == 3'b011) || (acc_f3 == 3'b110) || (acc_f3 == 3'b111) ||
               (acc_write && acc_f3[2]);
    misalign = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
               ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
    oor      = (acc_addr >> (AW + 2)) != '0;
    err      = f3_bad || misalign || oor;

    case (acc_addr[1:0])
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = acc_addr[1] ? word[31:16] : word[15:0];

    case (acc_f3)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_data = word;
      3'b100:  load_data = {24'd0, sel_byte};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = '0;
    endcase
    rdata = (err || acc_write) ? '0 : load_data;

    case (acc_f3[1:0])
      2'b00: begin
        be       = 4'b0001 << acc_addr[1:0];
        wd_lanes = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be       = acc_addr[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{acc_wdata[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wd_lanes = acc_wdata;
      end
    endcase

    // Gating on Rst keeps a store presented during reset from committing.
    we = enter_resp && acc_write && !err && Rst;
  end

  always_ff @(posedge Clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd_lanes[8*i +: 8];
      end
    end
  end

endmodule
